// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decoded instruction from IF/ID, or inserts a bubble when a
// load-use hazard is detected, a redirect flushes the stage, or IF/ID is empty.
// Also keeps a saturating count of the load-use bubbles it has inserted.
module idex_stage #(
  parameter int         DW    = 32,
  parameter logic [5:0] ALUOP = 6'b000000
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 ifid_valid,
  input  logic [5:0]           ifid_op,
  input  logic [4:0]           ifid_rs,
  input  logic [4:0]           ifid_rt,
  input  logic [4:0]           ifid_rd,
  input  logic signed [DW-1:0] ifid_a,
  input  logic signed [DW-1:0] ifid_b,
  input  logic signed [DW-1:0] ifid_imm,
  input  logic                 ifid_memread,
  input  logic                 ifid_memwrite,
  input  logic                 ifid_regwrite,
  input  logic                 flush,
  output logic                 idex_valid,
  output logic [5:0]           idex_op,
  output logic [4:0]           idex_rs,
  output logic [4:0]           idex_rt,
  output logic [4:0]           idex_dst,
  output logic signed [DW-1:0] idex_a,
  output logic signed [DW-1:0] idex_b,
  output logic signed [DW-1:0] idex_imm,
  output logic                 idex_memread,
  output logic                 idex_memwrite,
  output logic                 idex_regwrite,
  output logic                 stall,
  output logic [15:0]          stall_count
);

  logic                 valid_q, valid_d;
  logic [5:0]           op_q, op_d;
  logic [4:0]           rs_q, rs_d;
  logic [4:0]           rt_q, rt_d;
  logic [4:0]           dst_q, dst_d;
  logic signed [DW-1:0] a_q, a_d;
  logic signed [DW-1:0] b_q, b_d;
  logic signed [DW-1:0] imm_q, imm_d;
  logic                 memread_q, memread_d;
  logic                 memwrite_q, memwrite_d;
  logic                 regwrite_q, regwrite_d;
  logic [15:0]          stall_count_q, stall_count_d;
  logic                 capture;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    if (cnt == 16'hFFFF) begin
      return cnt;
    end
    return cnt + 16'd1;
  endfunction

  // Load-use detection: the load in ID/EX writes a register the IF/ID
  // instruction reads; rt is only a source operand for R-type ALU ops.
  always_comb begin
    stall = 1'b0;
    if (resetn && valid_q && memread_q && (rt_q != 5'd0) && ifid_valid &&
        ((rt_q == ifid_rs) || ((ifid_op == ALUOP) && (rt_q == ifid_rt)))) begin
      stall = 1'b1;
    end
  end

  assign capture = ifid_valid && !stall && !flush;

  // Next stage contents: real capture, or an all-zero bubble.
  always_comb begin
    valid_d       = 1'b0;
    op_d          = '0;
    rs_d          = '0;
    rt_d          = '0;
    dst_d         = '0;
    a_d           = '0;
    b_d           = '0;
    imm_d         = '0;
    memread_d     = 1'b0;
    memwrite_d    = 1'b0;
    regwrite_d    = 1'b0;
    stall_count_d = stall ? sat_inc(stall_count_q) : stall_count_q;
    if (capture) begin
      valid_d    = 1'b1;
      op_d       = ifid_op;
      rs_d       = ifid_rs;
      rt_d       = ifid_rt;
      a_d        = ifid_a;
      b_d        = ifid_b;
      imm_d      = ifid_imm;
      memread_d  = ifid_memread;
      memwrite_d = ifid_memwrite;
      regwrite_d = ifid_regwrite;
      if (ifid_regwrite) begin
        dst_d = (ifid_op == ALUOP) ? ifid_rd : ifid_rt;
      end
    end
  end

  // ID/EX register; reset clears every field including the bubble counter.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_q       <= 1'b0;
      op_q          <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      dst_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      imm_q         <= '0;
      memread_q     <= 1'b0;
      memwrite_q    <= 1'b0;
      regwrite_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      op_q          <= op_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      dst_q         <= dst_d;
      a_q           <= a_d;
      b_q           <= b_d;
      imm_q         <= imm_d;
      memread_q     <= memread_d;
      memwrite_q    <= memwrite_d;
      regwrite_q    <= regwrite_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign idex_valid    = valid_q;
  assign idex_op       = op_q;
  assign idex_rs       = rs_q;
  assign idex_rt       = rt_q;
  assign idex_dst      = dst_q;
  assign idex_a        = a_q;
  assign idex_b        = b_q;
  assign idex_imm      = imm_q;
  assign idex_memread  = memread_q;
  assign idex_memwrite = memwrite_q;
  assign idex_regwrite = regwrite_q;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_idex_stage.sv
// Testbench for idex_stage: directed hazard scenarios plus a randomized run
// checked against a transaction-level model of the ID/EX register.
module tb_idex_stage;
  localparam int         DW    = 32;
  localparam logic [5:0] ALUOP = 6'b000000;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam int         VW    = 1 + 6 + 5 + 5 + 5 + 3 * DW + 3 + 16;

  logic          clock = 1'b0;
  logic          resetn;
  logic          ifid_valid;
  logic [5:0]    ifid_op;
  logic [4:0]    ifid_rs, ifid_rt, ifid_rd;
  logic [DW-1:0] ifid_a, ifid_b, ifid_imm;
  logic          ifid_memread, ifid_memwrite, ifid_regwrite;
  logic          flush;
  logic          idex_valid;
  logic [5:0]    idex_op;
  logic [4:0]    idex_rs, idex_rt, idex_dst;
  logic [DW-1:0] idex_a, idex_b, idex_imm;
  logic          idex_memread, idex_memwrite, idex_regwrite;
  logic          stall;
  logic [15:0]   stall_count;

  int tests = 0;
  int fails = 0;

  // Reference model: contents of the ID/EX stage as an instruction record.
  typedef struct packed {
    logic          valid;
    logic [5:0]    op;
    logic [4:0]    rs, rt, dst;
    logic [DW-1:0] a, b, imm;
    logic          mr, mw, rw;
  } instr_t;
  instr_t      m_ex;
  logic [15:0] m_cnt;

  idex_stage #(.DW(DW), .ALUOP(ALUOP)) dut (
    .clock(clock), .resetn(resetn),
    .ifid_valid(ifid_valid), .ifid_op(ifid_op),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rd(ifid_rd),
    .ifid_a(ifid_a), .ifid_b(ifid_b), .ifid_imm(ifid_imm),
    .ifid_memread(ifid_memread), .ifid_memwrite(ifid_memwrite),
    .ifid_regwrite(ifid_regwrite), .flush(flush),
    .idex_valid(idex_valid), .idex_op(idex_op),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_dst(idex_dst),
    .idex_a(idex_a), .idex_b(idex_b), .idex_imm(idex_imm),
    .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
    .idex_regwrite(idex_regwrite), .stall(stall), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  // Does the current IF/ID instruction need a value the ID/EX load has not produced yet?
  function automatic logic model_stall();
    logic reads_rt;
    reads_rt = (ifid_op == ALUOP);
    return resetn && m_ex.valid && m_ex.mr && (m_ex.rt != 5'd0) && ifid_valid &&
           ((m_ex.rt == ifid_rs) || (reads_rt && m_ex.rt == ifid_rt));
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {idex_valid, idex_op, idex_rs, idex_rt, idex_dst, idex_a, idex_b,
            idex_imm, idex_memread, idex_memwrite, idex_regwrite, stall_count};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_ex.valid, m_ex.op, m_ex.rs, m_ex.rt, m_ex.dst, m_ex.a, m_ex.b,
            m_ex.imm, m_ex.mr, m_ex.mw, m_ex.rw, m_cnt};
  endfunction

  // One clock: advance the model by the stage rules, then let the DUT settle.
  task automatic tick();
    logic   s;
    instr_t nxt;
    s   = model_stall();
    nxt = '0;
    if (ifid_valid && !s && !flush) begin
      nxt.valid = 1'b1;  nxt.op = ifid_op;  nxt.rs = ifid_rs;  nxt.rt = ifid_rt;
      nxt.a = ifid_a;    nxt.b = ifid_b;    nxt.imm = ifid_imm;
      nxt.mr = ifid_memread;  nxt.mw = ifid_memwrite;  nxt.rw = ifid_regwrite;
      nxt.dst = !ifid_regwrite ? 5'd0 : (ifid_op == ALUOP ? ifid_rd : ifid_rt);
    end
    @(posedge clock);
    if (!resetn) begin
      m_ex  = '0;
      m_cnt = 16'd0;
    end else begin
      m_ex = nxt;
      if (s && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic mr, input logic mw, input logic rw);
    ifid_valid = v;  ifid_op = op;  ifid_rs = rs;  ifid_rt = rt;  ifid_rd = rd;
    ifid_a = $urandom;  ifid_b = $urandom;  ifid_imm = $urandom;
    ifid_memread = mr;  ifid_memwrite = mw;  ifid_regwrite = rw;
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;  flush = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;  flush = 1'b0;
    set_instr(1'b1, ALUOP, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (dut_vec() !== '0 || stall !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold cycle %0d: got %h stall=%b, expected all zero", i, dut_vec(), stall);
      end
    end
    resetn = 1'b1;
    tick();
    tests++;
    if (idex_valid !== 1'b1 || idex_dst !== 5'd3 || idex_rs !== 5'd1) begin
      fails++;
      $display("FAIL reset_release: valid=%b dst=%0d rs=%0d, expected 1/3/1", idex_valid, idex_dst, idex_rs);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(1'b1, OP_LW, 5'd2, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    set_instr(1'b1, ALUOP, 5'd5, 5'd9, 5'd10, 1'b0, 1'b0, 1'b1);
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL load_use_stall: got %b, expected 1", stall);
    end
    tick();
    tests++;
    if (idex_valid !== 1'b0 || idex_regwrite !== 1'b0 || stall_count !== 16'd1 || stall !== 1'b0) begin
      fails++;
      $display("FAIL load_use_bubble: valid=%b rw=%b cnt=%0d stall=%b, expected 0/0/1/0",
               idex_valid, idex_regwrite, stall_count, stall);
    end
    tick();
    tests++;
    if (idex_valid !== 1'b1 || idex_rs !== 5'd5 || idex_op !== ALUOP || idex_dst !== 5'd10) begin
      fails++;
      $display("FAIL load_use_capture: valid=%b rs=%0d op=%h dst=%0d, expected 1/5/%h/10",
               idex_valid, idex_rs, idex_op, ALUOP, idex_dst);
    end
  endtask

  task automatic test_store_rt();
    do_reset();
    set_instr(1'b1, OP_LW, 5'd1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    set_instr(1'b1, OP_SW, 5'd3, 5'd7, 5'd12, 1'b0, 1'b1, 1'b1);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL store_rt_stall: got %b, expected 0", stall);
    end
    tick();
    tests++;
    if (idex_valid !== 1'b1 || idex_dst !== 5'd7 || idex_memwrite !== 1'b1 || stall_count !== 16'd0) begin
      fails++;
      $display("FAIL store_rt_capture: valid=%b dst=%0d mw=%b cnt=%0d, expected 1/7/1/0",
               idex_valid, idex_dst, idex_memwrite, stall_count);
    end
  endtask

  task automatic test_load_zero();
    do_reset();
    set_instr(1'b1, OP_LW, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    set_instr(1'b1, ALUOP, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL load_zero_stall: got %b, expected 0", stall);
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    set_instr(1'b1, OP_LW, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    set_instr(1'b1, ALUOP, 5'd6, 5'd5, 5'd8, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    tick();
    tests++;
    if (idex_valid !== 1'b0 || stall_count !== 16'd1) begin
      fails++;
      $display("FAIL flush_stall_bubble: valid=%b cnt=%0d, expected 0/1", idex_valid, stall_count);
    end
    flush = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_stall_second: stall=%b, expected 0", stall);
    end
    tick();
    tests++;
    if (idex_valid !== 1'b1 || idex_rt !== 5'd5 || stall_count !== 16'd1) begin
      fails++;
      $display("FAIL flush_stall_capture: valid=%b rt=%0d cnt=%0d, expected 1/5/1", idex_valid, idex_rt, stall_count);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    set_instr(1'b0, ALUOP, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
    tick();
    tests++;
    if (dut_vec() !== '0) begin
      fails++;
      $display("FAIL invalid_bubble: got %h, expected all zero", dut_vec());
    end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_cnt [3];
    exp_cnt[0] = 16'hFFFF;  exp_cnt[1] = 16'hFFFF;  exp_cnt[2] = 16'hFFFF;
    do_reset();
    force dut.stall_count_q = 16'hFFFE;
    #1;
    release dut.stall_count_q;
    m_cnt = 16'hFFFE;
    #1;
    tests++;
    if (stall_count !== 16'hFFFE) begin
      fails++;
      $display("FAIL sat_preload: got %h, expected fffe", stall_count);
    end
    for (int i = 0; i < 3; i++) begin
      set_instr(1'b1, OP_LW, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
      tick();
      set_instr(1'b1, ALUOP, 5'd5, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
      tick();
      tests++;
      if (stall_count !== exp_cnt[i]) begin
        fails++;
        $display("FAIL sat_count stall %0d: got %h, expected %h", i, stall_count, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_instr(1'b1, OP_LW, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    set_instr(1'b1, ALUOP, 5'd5, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    resetn = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL rst_stall_comb: stall=%b, expected 0", stall);
    end
    tick();
    tests++;
    if (dut_vec() !== '0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_stall: got %h stall=%b, expected all zero", dut_vec(), stall);
    end
    resetn = 1'b1;
    #1;
    tick();
    tests++;
    if (idex_valid !== 1'b1 || idex_rs !== 5'd5 || idex_dst !== 5'd3 || stall_count !== 16'd0) begin
      fails++;
      $display("FAIL rst_recover: valid=%b rs=%0d dst=%0d cnt=%0d, expected 1/5/3/0",
               idex_valid, idex_rs, idex_dst, stall_count);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [4];
    ops[0] = ALUOP;  ops[1] = OP_LW;  ops[2] = OP_SW;  ops[3] = 6'h08;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(99) != 0);
      flush  = ($urandom_range(9) == 0);
      set_instr($urandom_range(9) < 8, ops[$urandom_range(3)], 5'($urandom_range(3)),
                5'($urandom_range(3)), 5'($urandom_range(31)), $urandom_range(9) < 4,
                $urandom_range(1) == 1, $urandom_range(3) != 0);
      tests++;
      if (stall !== model_stall()) begin
        fails++;
        $display("FAIL rand_stall cycle %0d: got %b, expected %b", i, stall, model_stall());
      end
      tick();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL rand_state cycle %0d: got %h, expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    m_ex  = '0;
    m_cnt = 16'd0;
    resetn = 1'b0;
    flush  = 1'b0;
    set_instr(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    test_reset();
    test_load_use();
    test_store_rt();
    test_load_zero();
    test_flush_stall();
    test_invalid();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
